// File: rtl/kser_defs.sv
// Shared KSER definitions: FSM state encodings and default frame geometry,
// also consumed by the Kanalog buffer build.
package kser_defs;

    localparam int unsigned KSER_N_DEF       = 24;
    localparam int unsigned KSER_DIV_DEF     = 4;
    localparam int unsigned KSER_LATCH_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_TAIL  = 3'd3,
        ST_LATCH = 3'd4
    } kser_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kser_tick.sv
// Phase-length counter: counts from 0 after clear and flags the last cycle
// of a len-cycle phase.
module kser_tick #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         kreset,
    input  logic         clear,
    input  logic [W-1:0] len,
    output logic         term_c
);

    logic [W-1:0] cnt;

    assign term_c = (cnt == (len - W'(1)));

    always_ff @(posedge clk or negedge kreset) begin
        if (!kreset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/kser_master.sv
// Serial shift/latch initiator: shifts tx_data out MSB first on sdout/sclk,
// captures sdin on each sclk rise, then strobes slatch and reports rx_data.
module kser_master
    import kser_defs::*;
#(
    parameter int unsigned N       = KSER_N_DEF,
    parameter int unsigned DIV     = KSER_DIV_DEF,
    parameter int unsigned LATCH_W = KSER_LATCH_W_DEF
) (
    input  logic         clk,
    input  logic         kreset,
    input  logic         start,
    input  logic [N-1:0] tx_data,
    input  logic         sdin,
    output logic         sclk,
    output logic         sdout,
    output logic         slatch,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rx_data
);

    localparam int unsigned PH_W = $clog2(max_u(DIV, LATCH_W) + 1);
    localparam int unsigned BW   = $clog2(N + 1);

    kser_state_e   state;
    logic [BW-1:0] bit_cnt;
    logic [N-1:0]  tx_sr;
    logic [N-1:0]  rx_sr;
    logic [PH_W-1:0] ph_len;
    logic          ph_clear;
    logic          ph_term_c;

    // sdout is the MSB of the tx register; the shift after the last bit
    // leaves it all-zero, which keeps sdout low through TAIL and IDLE.
    assign sdout = tx_sr[N-1];

    assign ph_len   = (state == ST_LATCH) ? PH_W'(LATCH_W) : PH_W'(DIV);
    assign ph_clear = (state == ST_IDLE) || ph_term_c;

    kser_tick #(
        .W (PH_W)
    ) u_tick (
        .clk    (clk),
        .kreset (kreset),
        .clear  (ph_clear),
        .len    (ph_len),
        .term_c (ph_term_c)
    );

    always_ff @(posedge clk or negedge kreset) begin
        if (!kreset) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            sclk    <= 1'b0;
            slatch  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sr   <= tx_data;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (ph_term_c) begin
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[N-2:0], sdin};
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // Data only moves on the edge that drops sclk.
                    if (ph_term_c) begin
                        sclk    <= 1'b0;
                        tx_sr   <= {tx_sr[N-2:0], 1'b0};
                        bit_cnt <= bit_cnt + BW'(1);
                        state   <= (bit_cnt == BW'(N - 1)) ? ST_TAIL : ST_LOW;
                    end
                end
                ST_TAIL: begin
                    if (ph_term_c) begin
                        slatch <= 1'b1;
                        state  <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (ph_term_c) begin
                        slatch  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/kser_master.md
KSER_MASTER -- requirements
Module: kser_master

Interface
REQ-001 Parameters SHALL be:
- N, default 24: frame length in bits.
- DIV, default 4: clk cycles per sclk half-period, 1 or more.
- LATCH_W, default 4: clk cycles that slatch is held high, 1 or more.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, all state on its rising edge.
- kreset, in, 1: asynchronous, active-low reset.
- start, in, 1: frame request.
- tx_data, in, N: word to shift out, MSB first.
- sdin, in, 1: serial return data from the far-end shift chain.
- sclk, out, 1: serial clock.
- sdout, out, 1: serial data.
- slatch, out, 1: register-load strobe.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle end-of-frame pulse.
- rx_data, out, N: word captured from sdin.

Function
REQ-003 Initiator SHALL drive a serial stream that a sample-on-sclk-rise, load-on-slatch-rise shift/latch receiver accepts unchanged.

REQ-004 States SHALL be IDLE, LOW, HIGH, TAIL and LATCH; the state after reset SHALL be IDLE.

REQ-005 In IDLE with start=1, the block SHALL capture tx_data, clear the bit counter, assert busy, put tx_data[N-1] on sdout and enter LOW, all on the next edge.

REQ-006 LOW SHALL last DIV cycles with sclk=0, then enter HIGH.

REQ-007 On entry to HIGH the block SHALL set sclk=1 and shift sdin into the LSB of the rx shift register.

REQ-008 HIGH SHALL last DIV cycles, then:
- if fewer than N bits have been sent, increment the bit counter, present the next bit on sdout and enter LOW;
- after bit N, enter TAIL.

REQ-009 sdout SHALL change only on the edge that takes sclk low, never while sclk=1.

REQ-010 TAIL SHALL last DIV cycles with sclk=0, sdout=0, then enter LATCH.

REQ-011 LATCH SHALL hold slatch=1 for LATCH_W cycles, then return to IDLE.

REQ-012 On the LATCH-to-IDLE edge the block SHALL, in the same cycle:
- drop busy;
- pulse done for exactly 1 cycle;
- load rx_data from the rx shift register.

REQ-013 busy SHALL be high for exactly 2*N*DIV + DIV + LATCH_W cycles per frame.

REQ-014 start while busy=1 SHALL be ignored with no queuing.

REQ-015 start held high continuously SHALL begin a new frame on the cycle after done, with no other gap.

REQ-016 rx_data SHALL hold its value between frames and change only at done.

REQ-017 The bit counter SHALL be $clog2(N+1) bits wide and SHALL NOT wrap within a frame.

REQ-018 Phase counters SHALL be sized for the larger of DIV and LATCH_W.

REQ-019 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-020 While kreset=0, the block SHALL hold IDLE with sclk=0, sdout=0, slatch=0, busy=0, done=0, rx_data=0 and all counters and shift registers at 0.

REQ-021 Reset asserted mid-frame SHALL abort the frame at once with no slatch pulse and no done pulse.

REQ-022 After kreset rises, the first start SHALL be honoured on the first clk edge.

Structure
REQ-023 State encodings and the default N, DIV and LATCH_W values SHALL live in a shared include, kser_defs, which the Kanalog buffer build also uses.

REQ-024 The block SHALL contain one sub-module, kser_tick: a phase-length counter with a clear input that issues a one-cycle terminal pulse after a programmable count.

REQ-025 The rx and tx shift registers SHALL stay inside kser_master.

Verification
REQ-026 Test with N=8, DIV=2, LATCH_W=3 and tx_data=0xA5:
- the sdout values sampled at sclk rises SHALL read 1,0,1,0,0,1,0,1;
- busy SHALL be high for 37 cycles;
- slatch SHALL be high for 3 cycles;
- done SHALL pulse once.

REQ-027 With N=8 and a sdin model returning 0x3C MSB first, updated on sclk falls, rx_data SHALL equal 0x3C at done and hold it afterwards.

REQ-028 Back-to-back frames with start held high and tx_data = 0xFF then 0x00:
- the second frame SHALL start the cycle after done;
- each frame SHALL contain 8 sclk pulses;
- there SHALL be 2 slatch pulses.

REQ-029 A start pulse at bit 4 of an active frame SHALL have no effect: the frame length and contents stay unchanged and only 1 done is seen.

REQ-030 kreset=0 asserted during HIGH of bit 3 SHALL, within the same cycle:
- drive sclk, sdout, slatch, busy and done to 0 and rx_data to 0;
- produce no slatch pulse;
- and the next start SHALL produce a complete, correct frame.

REQ-031 Loopback test with the Kanalog buffer receiver model, N=8, tx_data=0x5A: the receiver's parallel output SHALL show 0x5A after the slatch rise.
